// File: rtl/multicycle_controller.sv
// Control unit for a bus-based multicycle CPU datapath.
// Sequences fetch, operand-word fetch, addressing-mode resolution, execute
// and write-back. Outputs are registered from the next state. The only
// exception is the MDR capture on a read wait, which must follow mfc within
// the same cycle.
//
// state | meaning
// RST   | reset, PC clear asserted
// F1    | PC -> MAR and Y
// F2    | instruction read, wait on mfc
// F3    | MDR -> IR, Y + 1 -> T
// F4    | T -> PC, decode
// W1    | PC -> MAR and Y for the operand word
// W2    | operand word read, wait on mfc
// W3    | Y + 1 -> T
// W4    | T -> PC
// X1    | index register -> Y
// X2    | Y + MDR -> T
// X3    | T -> MAR
// A1    | MDR -> MAR (absolute / indirect pointer)
// M1    | data read, wait on mfc
// E1    | destination register -> Y
// E2    | ALU operation on operand -> T / flags
// E3    | T -> destination register
// LD    | operand -> destination register
// S1    | destination register -> MDR
// S2    | MDR -> memory, wait on mfc
// JT    | branch taken, MDR -> PC
// L1    | PC -> link register
// L2    | MDR -> PC
// JR    | source register -> PC
module multicycle_controller (
    input  logic       clk,
    input  logic       rstIn,
    input  logic       mfc,
    input  logic       Dcondn,
    input  logic [6:0] irContr,
    output logic       rd,
    output logic       wr,
    output logic       LPC,
    output logic       TPC,
    output logic       LT,
    output logic       TT,
    output logic       LMAR,
    output logic       TMAR,
    output logic       LIR,
    output logic       RMDRExt,
    output logic       RMDRInt,
    output logic       TMDR2X,
    output logic       TMDR2Ext,
    output logic       TMDR2IR,
    output logic       LMDR,
    output logic       LregY,
    output logic       T1,
    output logic       Lflag,
    output logic       rdM,
    output logic       wrM,
    output logic       PCrst,
    output logic [1:0] fnSel,
    output logic [1:0] selreg
);

    typedef enum logic [4:0] {
        S_RST, S_F1, S_F2, S_F3, S_F4, S_W1, S_W2, S_W3, S_W4,
        S_X1, S_X2, S_X3, S_A1, S_M1, S_E1, S_E2, S_E3, S_LD,
        S_S1, S_S2, S_JT, S_L1, S_L2, S_JR
    } state_t;

    typedef enum logic [2:0] {
        K_ALU, K_MNS, K_CMP, K_LOAD, K_STORE, K_JCC, K_JAL, K_JR
    } kind_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       lpc;
        logic       tpc;
        logic       lt;
        logic       tt;
        logic       lmar;
        logic       tmar;
        logic       lir;
        logic       rmdr_int;
        logic       tmdr2x;
        logic       tmdr2ext;
        logic       tmdr2ir;
        logic       lmdr;
        logic       lregy;
        logic       t1;
        logic       lflag;
        logic       rdm;
        logic       wrm;
        logic       pcrst;
        logic [1:0] fn_sel;
        logic [1:0] sel_reg;
    } ctrl_t;

    state_t     state;
    state_t     nxt;
    state_t     exec_start;
    state_t     resolve_start;
    kind_t      kind;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl_nxt;
    logic       rd_wait_q;
    logic       ind_pass;
    logic       need_word;
    logic       is_store;
    logic       ind_first;
    logic [1:0] cls;
    logic [1:0] sub;
    logic [2:0] mode;

    assign cls  = irContr[6:5];
    assign sub  = irContr[4:3];
    assign mode = irContr[2:0];

    // Instruction kind from the IR control field, in decode priority order
    always_comb begin
        kind = K_ALU;
        if (cls == 2'b11 && mode == 3'b111)                     kind = K_JAL;
        else if (cls == 2'b11 && sub == 2'b11 && mode == 3'b000) kind = K_JR;
        else if (cls == 2'b11)                                  kind = K_JCC;
        else if (mode == 3'b110)                                kind = K_CMP;
        else if (cls == 2'b10 && sub[1])                        kind = K_STORE;
        else if (cls == 2'b10)                                  kind = K_LOAD;
        else if (cls == 2'b01)                                  kind = K_MNS;
        else                                                    kind = K_ALU;
    end

    assign need_word = (mode == 3'b000) || (mode == 3'b010) || (mode == 3'b011) ||
                       (mode == 3'b100) || (kind == K_JCC) || (kind == K_JAL);
    assign is_store  = (kind == K_STORE);
    // Indirect mode makes two MAR/MDR passes; the first one always reads.
    assign ind_first = (mode == 3'b100) && !ind_pass;

    // Entry points into execute and into address resolution
    always_comb begin
        exec_start = S_F1;
        case (kind)
            K_ALU, K_CMP: exec_start = S_E1;
            K_MNS:        exec_start = S_E2;
            K_LOAD:       exec_start = S_LD;
            K_STORE:      exec_start = (mode == 3'b000 || mode == 3'b001) ? S_F1 : S_S1;
            default:      exec_start = S_F1;
        endcase

        resolve_start = exec_start;
        case (kind)
            K_JCC:   resolve_start = Dcondn ? S_JT : S_F1;
            K_JAL:   resolve_start = S_L1;
            K_JR:    resolve_start = S_JR;
            default: begin
                if (mode == 3'b010)                          resolve_start = S_X1;
                else if (mode == 3'b011 || mode == 3'b100)   resolve_start = S_A1;
                else                                         resolve_start = exec_start;
            end
        endcase
    end

    // Next-state selection; mfc only matters in the four wait states
    always_comb begin
        nxt = S_RST;
        case (state)
            S_RST: nxt = S_F1;
            S_F1:  nxt = S_F2;
            S_F2:  nxt = mfc ? S_F3 : S_F2;
            S_F3:  nxt = S_F4;
            S_F4:  nxt = need_word ? S_W1 : resolve_start;
            S_W1:  nxt = S_W2;
            S_W2:  nxt = mfc ? S_W3 : S_W2;
            S_W3:  nxt = S_W4;
            S_W4:  nxt = resolve_start;
            S_X1:  nxt = S_X2;
            S_X2:  nxt = S_X3;
            S_X3:  nxt = is_store ? exec_start : S_M1;
            S_A1:  nxt = (is_store && !ind_first) ? exec_start : S_M1;
            S_M1:  nxt = mfc ? (ind_first ? S_A1 : exec_start) : S_M1;
            S_E1:  nxt = S_E2;
            S_E2:  nxt = (kind == K_CMP) ? S_F1 : S_E3;
            S_E3:  nxt = S_F1;
            S_LD:  nxt = S_F1;
            S_S1:  nxt = S_S2;
            S_S2:  nxt = mfc ? S_F1 : S_S2;
            S_JT:  nxt = S_F1;
            S_L1:  nxt = S_L2;
            S_L2:  nxt = S_F1;
            S_JR:  nxt = S_F1;
            default: nxt = S_RST;
        endcase
    end

    // Control word for the state about to be entered
    always_comb begin
        ctrl_nxt       = '0;
        ctrl_nxt.pcrst = 1'b1;
        case (nxt)
            S_RST: ctrl_nxt.pcrst = 1'b0;
            S_F1, S_W1: begin
                ctrl_nxt.tpc   = 1'b1;
                ctrl_nxt.lmar  = 1'b1;
                ctrl_nxt.lregy = 1'b1;
            end
            S_F2, S_W2, S_M1: ctrl_nxt.rdm = 1'b1;
            S_F3: begin
                ctrl_nxt.tmdr2ir = 1'b1;
                ctrl_nxt.lir     = 1'b1;
                ctrl_nxt.t1      = 1'b1;
                ctrl_nxt.lt      = 1'b1;
            end
            S_F4, S_W4: begin
                ctrl_nxt.tt  = 1'b1;
                ctrl_nxt.lpc = 1'b1;
            end
            S_W3: begin
                ctrl_nxt.t1 = 1'b1;
                ctrl_nxt.lt = 1'b1;
            end
            S_X1: begin
                ctrl_nxt.rd      = 1'b1;
                ctrl_nxt.sel_reg = 2'b11;
                ctrl_nxt.lregy   = 1'b1;
            end
            S_X2: begin
                ctrl_nxt.tmdr2x = 1'b1;
                ctrl_nxt.lt     = 1'b1;
            end
            S_X3: begin
                ctrl_nxt.tt   = 1'b1;
                ctrl_nxt.lmar = 1'b1;
            end
            S_A1: begin
                ctrl_nxt.tmdr2x = 1'b1;
                ctrl_nxt.lmar   = 1'b1;
            end
            S_E1: begin
                ctrl_nxt.rd      = 1'b1;
                ctrl_nxt.sel_reg = 2'b01;
                ctrl_nxt.lregy   = 1'b1;
            end
            S_E2: begin
                if (mode == 3'b001) ctrl_nxt.rd = 1'b1;
                else                ctrl_nxt.tmdr2x = 1'b1;
                ctrl_nxt.lflag = 1'b1;
                if (kind == K_CMP) begin
                    ctrl_nxt.fn_sel = 2'b01;
                end else begin
                    ctrl_nxt.fn_sel = (kind == K_MNS) ? 2'b11 : 2'b10;
                    ctrl_nxt.lt     = 1'b1;
                end
            end
            S_E3: begin
                ctrl_nxt.tt      = 1'b1;
                ctrl_nxt.wr      = 1'b1;
                ctrl_nxt.sel_reg = 2'b01;
            end
            // Register-mode load reads and writes in one cycle; the register
            // field points at the destination for both.
            S_LD: begin
                if (mode == 3'b001) ctrl_nxt.rd = 1'b1;
                else                ctrl_nxt.tmdr2x = 1'b1;
                ctrl_nxt.wr      = 1'b1;
                ctrl_nxt.sel_reg = 2'b01;
            end
            S_S1: begin
                ctrl_nxt.rd       = 1'b1;
                ctrl_nxt.sel_reg  = 2'b01;
                ctrl_nxt.rmdr_int = 1'b1;
                ctrl_nxt.lmdr     = 1'b1;
            end
            S_S2: begin
                ctrl_nxt.tmdr2ext = 1'b1;
                ctrl_nxt.wrm      = 1'b1;
            end
            S_JT, S_L2: begin
                ctrl_nxt.tmdr2x = 1'b1;
                ctrl_nxt.lpc    = 1'b1;
            end
            S_L1: begin
                ctrl_nxt.tpc     = 1'b1;
                ctrl_nxt.wr      = 1'b1;
                ctrl_nxt.sel_reg = 2'b10;
            end
            S_JR: begin
                ctrl_nxt.rd      = 1'b1;
                ctrl_nxt.sel_reg = 2'b00;
                ctrl_nxt.lpc     = 1'b1;
            end
            default: ctrl_nxt.pcrst = 1'b1;
        endcase
    end

    // State, registered control word and indirect-pass tracking
    always_ff @(posedge clk) begin
        if (!rstIn) begin
            state     <= S_RST;
            ctrl_q    <= '0;
            rd_wait_q <= 1'b0;
            ind_pass  <= 1'b0;
        end else begin
            state     <= nxt;
            ctrl_q    <= ctrl_nxt;
            rd_wait_q <= (nxt == S_F2) || (nxt == S_W2) || (nxt == S_M1);
            if (state == S_M1 && mfc && ind_first) ind_pass <= 1'b1;
            else if (nxt == S_F1)                 ind_pass <= 1'b0;
        end
    end

    assign rd       = ctrl_q.rd;
    assign wr       = ctrl_q.wr;
    assign LPC      = ctrl_q.lpc;
    assign TPC      = ctrl_q.tpc;
    assign LT       = ctrl_q.lt;
    assign TT       = ctrl_q.tt;
    assign LMAR     = ctrl_q.lmar;
    assign TMAR     = ctrl_q.tmar;
    assign LIR      = ctrl_q.lir;
    assign RMDRExt  = rd_wait_q & mfc;
    assign RMDRInt  = ctrl_q.rmdr_int;
    assign TMDR2X   = ctrl_q.tmdr2x;
    assign TMDR2Ext = ctrl_q.tmdr2ext;
    assign TMDR2IR  = ctrl_q.tmdr2ir;
    assign LMDR     = ctrl_q.lmdr | (rd_wait_q & mfc);
    assign LregY    = ctrl_q.lregy;
    assign T1       = ctrl_q.t1;
    assign Lflag    = ctrl_q.lflag;
    assign rdM      = ctrl_q.rdm;
    assign wrM      = ctrl_q.wrm;
    assign PCrst    = ctrl_q.pcrst;
    assign fnSel    = ctrl_q.fn_sel;
    assign selreg   = ctrl_q.sel_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded by a
// behavioural model into its expected per-cycle control words and the DUT
// is stepped against that list with randomized mfc latency.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rstIn, mfc, Dcondn;
    logic [6:0] irContr;
    logic rd, wr, LPC, TPC, LT, TT, LMAR, TMAR, LIR, RMDRExt, RMDRInt;
    logic TMDR2X, TMDR2Ext, TMDR2IR, LMDR, LregY, T1, Lflag, rdM, wrM, PCrst;
    logic [1:0] fnSel, selreg;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [24:0] M_RD     = 25'd1 << 24;
    localparam logic [24:0] M_WR     = 25'd1 << 23;
    localparam logic [24:0] M_LPC    = 25'd1 << 22;
    localparam logic [24:0] M_TPC    = 25'd1 << 21;
    localparam logic [24:0] M_LT     = 25'd1 << 20;
    localparam logic [24:0] M_TT     = 25'd1 << 19;
    localparam logic [24:0] M_LMAR   = 25'd1 << 18;
    localparam logic [24:0] M_LIR    = 25'd1 << 16;
    localparam logic [24:0] M_RMEXT  = 25'd1 << 15;
    localparam logic [24:0] M_RMINT  = 25'd1 << 14;
    localparam logic [24:0] M_TM2X   = 25'd1 << 13;
    localparam logic [24:0] M_TM2EXT = 25'd1 << 12;
    localparam logic [24:0] M_TM2IR  = 25'd1 << 11;
    localparam logic [24:0] M_LMDR   = 25'd1 << 10;
    localparam logic [24:0] M_LREGY  = 25'd1 << 9;
    localparam logic [24:0] M_T1     = 25'd1 << 8;
    localparam logic [24:0] M_LFLAG  = 25'd1 << 7;
    localparam logic [24:0] M_RDM    = 25'd1 << 6;
    localparam logic [24:0] M_WRM    = 25'd1 << 5;
    localparam logic [24:0] M_PCR    = 25'd1 << 4;

    logic [24:0] obs;
    assign obs = {rd, wr, LPC, TPC, LT, TT, LMAR, TMAR, LIR, RMDRExt, RMDRInt,
                  TMDR2X, TMDR2Ext, TMDR2IR, LMDR, LregY, T1, Lflag, rdM, wrM,
                  PCrst, fnSel, selreg};

    multicycle_controller dut (
        .clk(clk), .rstIn(rstIn), .mfc(mfc), .Dcondn(Dcondn), .irContr(irContr),
        .rd(rd), .wr(wr), .LPC(LPC), .TPC(TPC), .LT(LT), .TT(TT), .LMAR(LMAR),
        .TMAR(TMAR), .LIR(LIR), .RMDRExt(RMDRExt), .RMDRInt(RMDRInt),
        .TMDR2X(TMDR2X), .TMDR2Ext(TMDR2Ext), .TMDR2IR(TMDR2IR), .LMDR(LMDR),
        .LregY(LregY), .T1(T1), .Lflag(Lflag), .rdM(rdM), .wrM(wrM),
        .PCrst(PCrst), .fnSel(fnSel), .selreg(selreg)
    );

    always #5 clk = ~clk;

    logic [24:0] exp_vec[$];
    bit          exp_wait[$];
    bit          exp_read[$];

    task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic [24:0] fn(input int v);
        logic [24:0] r;
        r = 25'(v) << 2;
        return r;
    endfunction

    function automatic logic [24:0] sel(input int v);
        logic [24:0] r;
        r = 25'(v);
        return r;
    endfunction

    task automatic push(input logic [24:0] v, input bit w, input bit r);
        exp_vec.push_back(v | M_PCR);
        exp_wait.push_back(w);
        exp_read.push_back(r);
    endtask

    // Expected control-word sequence of one instruction, F1 through its last state
    task automatic model_instr(input logic [6:0] ir, input logic dc);
        int cls, sub, mode;
        string k;
        bit st;
        logic [24:0] opnd;
        exp_vec.delete(); exp_wait.delete(); exp_read.delete();
        cls = int'(ir[6:5]); sub = int'(ir[4:3]); mode = int'(ir[2:0]);
        if (cls == 3 && mode == 7)                 k = "JAL";
        else if (cls == 3 && sub == 3 && mode == 0) k = "JR";
        else if (cls == 3)                         k = "JCC";
        else if (mode == 6)                        k = "CMP";
        else if (cls == 2 && sub >= 2)             k = "STORE";
        else if (cls == 2)                         k = "LOAD";
        else if (cls == 1)                         k = "MNS";
        else                                       k = "ALU";
        st   = (k == "STORE");
        opnd = (mode == 1) ? (M_RD | sel(0)) : M_TM2X;

        push(M_TPC | M_LMAR | M_LREGY, 0, 0);
        push(M_RDM, 1, 1);
        push(M_TM2IR | M_LIR | M_T1 | M_LT | fn(0), 0, 0);
        push(M_TT | M_LPC, 0, 0);
        if (mode == 0 || mode == 2 || mode == 3 || mode == 4 || k == "JCC" || k == "JAL") begin
            push(M_TPC | M_LMAR | M_LREGY, 0, 0);
            push(M_RDM, 1, 1);
            push(M_T1 | M_LT, 0, 0);
            push(M_TT | M_LPC, 0, 0);
        end
        if (k == "JCC") begin
            if (dc) push(M_TM2X | M_LPC, 0, 0);
        end else if (k == "JAL") begin
            push(M_TPC | M_WR | sel(2), 0, 0);
            push(M_TM2X | M_LPC, 0, 0);
        end else if (k == "JR") begin
            push(M_RD | sel(0) | M_LPC, 0, 0);
        end else begin
            if (mode == 2) begin
                push(M_RD | sel(3) | M_LREGY, 0, 0);
                push(M_TM2X | M_LT, 0, 0);
                push(M_TT | M_LMAR, 0, 0);
                if (!st) push(M_RDM, 1, 1);
            end else if (mode == 3) begin
                push(M_TM2X | M_LMAR, 0, 0);
                if (!st) push(M_RDM, 1, 1);
            end else if (mode == 4) begin
                push(M_TM2X | M_LMAR, 0, 0);
                push(M_RDM, 1, 1);
                push(M_TM2X | M_LMAR, 0, 0);
                if (!st) push(M_RDM, 1, 1);
            end
            case (k)
                "ALU": begin
                    push(M_RD | sel(1) | M_LREGY, 0, 0);
                    push(opnd | fn(2) | M_LT | M_LFLAG, 0, 0);
                    push(M_TT | M_WR | sel(1), 0, 0);
                end
                "MNS": begin
                    push(opnd | fn(3) | M_LT | M_LFLAG, 0, 0);
                    push(M_TT | M_WR | sel(1), 0, 0);
                end
                "CMP": begin
                    push(M_RD | sel(1) | M_LREGY, 0, 0);
                    push(opnd | fn(1) | M_LFLAG, 0, 0);
                end
                "LOAD": push(((mode == 1) ? M_RD : M_TM2X) | M_WR | sel(1), 0, 0);
                default: begin
                    if (mode >= 2) begin
                        push(M_RD | sel(1) | M_RMINT | M_LMDR, 0, 0);
                        push(M_TM2EXT | M_WRM, 1, 0);
                    end
                end
            endcase
        end
    endtask

    // Step the DUT through one instruction; abort_at >= 0 pulls reset during that wait
    task automatic run_instr(input logic [6:0] ir, input logic dc, input int abort_at);
        int d;
        irContr = ir;
        Dcondn  = dc;
        model_instr(ir, dc);
        for (int i = 0; i < exp_vec.size(); i++) begin
            if (exp_wait[i]) begin
                if (i == abort_at) begin
                    mfc = 1'b0;
                    #1 chk($sformatf("ir=%b wait%0d", ir, i), obs, exp_vec[i]);
                    rstIn = 1'b0;
                    @(posedge clk); #1;
                    chk("rst_in_wait", obs, 25'd0);
                    rstIn = 1'b1;
                    @(posedge clk); #1;
                    return;
                end
                d = $urandom_range(0, 3);
                for (int c = 0; c < d; c++) begin
                    mfc = 1'b0;
                    #1 chk($sformatf("ir=%b hold%0d", ir, i), obs, exp_vec[i]);
                    @(posedge clk); #1;
                end
                mfc = 1'b1;
                #1 chk($sformatf("ir=%b done%0d", ir, i), obs,
                       exp_vec[i] | (exp_read[i] ? (M_RMEXT | M_LMDR) : 25'd0));
                @(posedge clk); #1;
            end else begin
                mfc = 1'($urandom_range(0, 1));
                #1 chk($sformatf("ir=%b step%0d", ir, i), obs, exp_vec[i]);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        rstIn = 1'b0; mfc = 1'b0; Dcondn = 1'b0; irContr = 7'd0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset", obs, 25'd0);
        rstIn = 1'b1;
        @(posedge clk); #1;

        run_instr(7'b0010000, 0, -1);
        run_instr(7'b0100001, 0, -1);
        run_instr(7'b0001100, 0, -1);
        run_instr(7'b1011100, 0, -1);
        run_instr(7'b1101010, 0, -1);
        run_instr(7'b1101010, 1, -1);
        run_instr(7'b1110111, 0, -1);
        run_instr(7'b1111000, 0, -1);
        run_instr(7'b0011110, 0, -1);
        run_instr(7'b1000011, 0, -1);
        run_instr(7'b1000001, 0, -1);
        run_instr(7'b1010001, 0, -1);
        run_instr(7'b1010010, 0, -1);
        run_instr(7'b0000010, 0, -1);
        run_instr(7'b0010000, 0, 5);

        for (int n = 0; n < 80; n++)
            run_instr(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style FSM control unit for a bus-based multicycle CPU datapath (PC, MAR, MDR, IR, ALU Y latch, temp T, register file, flags).
- Sequences fetch, operand-word fetch, addressing-mode resolution, execute and write-back from the 7-bit IR control field.
- Drives per-state load (L*) and tristate (T*) enables, memory strobes and ALU/register selects.
- Waits on the memory-function-complete handshake for every memory access.

Parameters:
none

Ports:
clk  input  1  rising-edge clock
rstIn  input  1  reset, synchronous, active-low
mfc  input  1  memory function complete
Dcondn  input  1  branch condition true (evaluated by datapath from IR)
irContr  input  7  IR control field: [6:5] class, [4:3] sub-op, [2:0] mode
rd, wr  output  1  register-file read onto bus / write from bus
LPC, TPC  output  1  load PC / PC drives bus
LT, TT  output  1  load temp / temp drives bus
LMAR, TMAR  output  1  load MAR / MAR drives bus
LIR  output  1  load IR from MDR path
RMDRExt, RMDRInt  output  1  MDR input mux: external data / internal bus
TMDR2X, TMDR2Ext, TMDR2IR  output  1  MDR drives internal bus / external bus / IR path
LMDR, LregY, T1, Lflag  output  1  load MDR / load Y latch / constant 1 on bus / load flags
rdM, wrM  output  1  memory read / write strobe
PCrst  output  1  active-low PC clear
fnSel  output  2  ALU: 00 Y+bus, 01 Y-bus, 10 op from irContr[4:3], 11 0-bus
selreg  output  2  register field: 00 src, 01 dst, 10 link, 11 index

Behaviour:
- Reset: rstIn sampled low at any edge → state RST from any state, including memory waits. In RST all outputs 0 except PCrst=0. First edge with rstIn=1 → F1. PCrst=1 in every other state.
- Unlisted outputs are 0 in each state.
- Fetch:
  - F1: TPC, LMAR, LregY.
  - F2: rdM; hold while mfc=0. When mfc=1, also assert RMDRExt and LMDR, then go to F3.
  - F3: TMDR2IR, LIR, T1, fnSel=00, LT.
  - F4: TT, LPC, then decode.
- Decode (priority order):
  - class 11, mode 111 → JAL.
  - class 11, [4:3]=11, mode 000 → JR.
  - class 11, other → JCC.
  - mode 110 → CMP.
  - class 10 with [4]=1 → STORE.
  - class 10 → LOAD.
  - class 01 → MNS.
  - class 00 → ALU.
- Operand word: needed for modes 000/010/011/100, JCC and JAL.
  - W1: TPC, LMAR, LregY.
  - W2: rdM; wait on mfc as in F2; latch MDR.
  - W3: T1, fnSel=00, LT.
  - W4: TT, LPC.
- Address resolution (operand ends in MDR, or address in MAR for STORE):
  - 010 indexed:
    - X1: rd, selreg=11, LregY.
    - X2: TMDR2X, fnSel=00, LT.
    - X3: TT, LMAR.
  - 011 absolute: A1: TMDR2X, LMAR.
  - 100 indirect: A1, then M1, then A1, then M1.
  - M1 data read: rdM; wait on mfc; latch MDR. Skipped for STORE.
- Execute:
  - Operand source is rd/selreg=00 for mode 001, TMDR2X otherwise.
  - ALU:
    - E1: rd, selreg=01, LregY.
    - E2: operand, fnSel=10, LT, Lflag.
    - E3: TT, wr, selreg=01.
  - MNS: E2 with fnSel=11, then E3.
  - CMP: E1, then E2 with fnSel=01 and Lflag (no LT).
  - LOAD: operand, wr, selreg=01.
  - STORE:
    - S1: rd, selreg=01, RMDRInt, LMDR.
    - S2: TMDR2Ext, wrM, hold until mfc=1.
    - STORE with mode 000/001 executes as a no-op.
  - JCC: if Dcondn=1, TMDR2X, LPC; else nothing.
  - JAL:
    - L1: TPC, wr, selreg=10.
    - L2: TMDR2X, LPC.
  - JR: rd, selreg=00, LPC.
- Every instruction returns to F1 after its last state.
- Memory waits: rdM/wrM stay high for the whole wait. mfc is sampled only in wait states. mfc high on entry completes in one cycle.

Test Plan:
- rstIn=0 two edges → PCrst=0, all else 0; release, irContr=0010000, mfc rises 3 cycles later → F1..F4, W1..W4, E1..E3 sequence; E2 has fnSel=10 with LT and Lflag; E3 has wr with selreg=01; back to F1.
- irContr=0100001 (MNS reg) → E2 rd selreg=00, fnSel=11; E3 write-back; no W states.
- irContr=0001100 (ALU indirect) with mfc delayed each access → exactly four memory waits (F2, W2, two M1); no state advance while mfc=0.
- irContr=1011100 (STORE indirect) → S2 asserts wrM with TMDR2Ext until mfc=1, then F1.
- irContr=1101010 with Dcondn=0, then Dcondn=1 → LPC only in the Dcondn=1 case.
- irContr=1110111 then 1111000 → JAL writes link (selreg=10) then LPC; JR asserts rd selreg=00 with LPC. Assert rstIn=0 during a W2 wait → RST next edge.
